// File: rtl/seg_display_pkg.sv
// Shared constants for the 8-digit seven-segment controller: digit count, segment bit map, hex decode table, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg_display_pkg;

    localparam int NUM_DIGITS = 8;

    // Segment bit positions within an 8-bit pattern (1 = lit)
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Hex glyphs, indexed by nibble; entry 15 is listed first
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/seg_display_ctrl_hex_to_seg.sv
// Nibble + decimal point to seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module hex_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    // Table lookup for a..g, decimal point passed straight through
    always_comb begin
        seg         = SEG_TABLE[nibble];
        seg[SEG_DP] = dp;
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Two-requester shadow store for 8 hex digits, copied to the live outputs on each vga_vs falling edge; optional macro SEG_BLANK_LEADING_ZEROS_EN blanks leading zero digits.
// Latency: gnt one cycle after IDLE samples req; hex outputs update in the COMMIT cycle following a vs fall.
// Backpressure: requesters hold req/data until gnt; a pending commit takes priority over writes.
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                clk50,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   req_digit,
    input  logic [4*NREQ-1:0]   req_nibble,
    input  logic [NREQ-1:0]     req_dp,
    output logic [NREQ-1:0]     gnt,
    input  logic                vga_vs,
    output logic [7:0]          hex0,
    output logic [7:0]          hex1,
    output logic [7:0]          hex2,
    output logic [7:0]          hex3,
    output logic [7:0]          hex4,
    output logic [7:0]          hex5,
    output logic [7:0]          hex6,
    output logic [7:0]          hex7,
    output logic [15:0]         commit_cnt
);

    state_t                 state;
    logic                   win;
    logic                   ptr;
    logic                   pick;
    logic [3:0]             sh_nib [NUM_DIGITS];
    logic                   sh_dp  [NUM_DIGITS];
    logic [7:0]             seg    [NUM_DIGITS];
    logic [7:0]             hex_r  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  blank;
    logic                   vs_q;
    logic                   vs_fall;
    logic                   commit_pending;
    logic [2:0]             wr_digit;
    logic [3:0]             wr_nib;
    logic                   wr_dp;

    assign vs_fall = vs_q & ~vga_vs;

    // Tie goes to the requester that was not granted last
    assign pick = (req[0] & req[1]) ? ~ptr : req[1];

    assign wr_digit = win ? req_digit[5:3]  : req_digit[2:0];
    assign wr_nib   = win ? req_nibble[7:4] : req_nibble[3:0];
    assign wr_dp    = win ? req_dp[1]       : req_dp[0];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex_to_seg u_dec (
            .nibble (sh_nib[g]),
            .dp     (sh_dp[g]),
            .seg    (seg[g])
        );
    end

`ifdef SEG_BLANK_LEADING_ZEROS_EN
    // A digit blanks when it and every higher digit hold zero and its own dp is off; digit 0 always shows
    always_comb begin : blank_calc
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (sh_nib[i] == 4'h0);
            blank[i]   = zero_above & ~sh_dp[i];
        end
    end
`else
    assign blank = '0;
`endif

    // Frame edge detect; a new edge outranks the clear so a commit is never dropped
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            vs_q           <= 1'b1;
            commit_pending <= 1'b0;
        end else begin
            vs_q <= vga_vs;
            if (vs_fall)
                commit_pending <= 1'b1;
            else if (state == ST_COMMIT)
                commit_pending <= 1'b0;
        end
    end

    // Control FSM with shadow store, live outputs and commit counter
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            win        <= 1'b0;
            ptr        <= 1'b1;
            commit_cnt <= 16'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sh_nib[i] <= 4'h0;
                sh_dp[i]  <= 1'b0;
                hex_r[i]  <= 8'h00;
            end
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (commit_pending) begin
                        state <= ST_COMMIT;
                    end else if (|req) begin
                        state     <= ST_WRITE;
                        win       <= pick;
                        gnt[pick] <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // A request dropped before its grant leaves the store untouched
                    if (req[win]) begin
                        sh_nib[wr_digit] <= wr_nib;
                        sh_dp[wr_digit]  <= wr_dp;
                        ptr              <= win;
                    end
                    state <= ST_IDLE;
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        hex_r[i] <= blank[i] ? 8'h00 : seg[i];
                    commit_cnt <= commit_cnt + 16'd1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign hex0 = hex_r[0];
    assign hex1 = hex_r[1];
    assign hex2 = hex_r[2];
    assign hex3 = hex_r[3];
    assign hex4 = hex_r[4];
    assign hex5 = hex_r[5];
    assign hex6 = hex_r[6];
    assign hex7 = hex_r[7];

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed writes and frame edges, grant/commit scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_display_ctrl;

    logic        clk50 = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [5:0]  req_digit;
    logic [7:0]  req_nibble;
    logic [1:0]  req_dp;
    logic [1:0]  gnt;
    logic        vga_vs;
    logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [15:0] commit_cnt;

    seg_display_ctrl #(.NREQ(2)) dut (
        .clk50      (clk50),
        .reset      (reset),
        .req        (req),
        .req_digit  (req_digit),
        .req_nibble (req_nibble),
        .req_dp     (req_dp),
        .gnt        (gnt),
        .vga_vs     (vga_vs),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .hex6       (hex6),
        .hex7       (hex7),
        .commit_cnt (commit_cnt)
    );

    always #10 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] cnt;
        logic [63:0] hexes;
    } commit_t;

    int          tests = 0;
    int          fails = 0;
    commit_t     exp_commit[$];
    logic [1:0]  exp_gnt[$];
    logic [3:0]  m_nib [8];
    logic        m_dp  [8];
    logic [7:0]  m_hex [8];
    logic [15:0] exp_cnt;
    logic [15:0] prev_cnt = 16'd0;
    int          lat;

    wire [63:0] hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    function automatic logic [7:0] dec(input logic [3:0] n, input logic dp);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return {dp, p};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_nib[i] = 4'h0;
            m_dp[i]  = 1'b0;
            m_hex[i] = 8'h00;
        end
        exp_cnt = 16'd0;
    endtask

    // Expected live outputs after the next commit, from the bench's own shadow model
    task automatic push_commit();
        commit_t c;
`ifdef SEG_BLANK_LEADING_ZEROS_EN
        logic zero_above = 1'b1;
`endif
        for (int i = 7; i >= 0; i--) begin
            m_hex[i] = dec(m_nib[i], m_dp[i]);
`ifdef SEG_BLANK_LEADING_ZEROS_EN
            zero_above = zero_above & (m_nib[i] == 4'h0);
            if (i >= 1 && zero_above && !m_dp[i]) m_hex[i] = 8'h00;
`endif
            c.hexes[i*8 +: 8] = m_hex[i];
        end
        exp_cnt = exp_cnt + 16'd1;
        c.cnt   = exp_cnt;
        exp_commit.push_back(c);
    endtask

    task automatic wait_commit();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk50);
            if (commit_cnt == exp_cnt) return;
        end
        chk("commit_timeout", 64'(commit_cnt), 64'(exp_cnt));
    endtask

    task automatic vs_commit();
        push_commit();
        @(posedge clk50); #1 vga_vs = 1'b0;
        @(posedge clk50); #1 vga_vs = 1'b1;
        wait_commit();
    endtask

    task automatic set_req(input int r, input logic [2:0] d, input logic [3:0] n, input logic dp);
        req_digit[r*3 +: 3]  = d;
        req_nibble[r*4 +: 4] = n;
        req_dp[r]            = dp;
        req[r]               = 1'b1;
    endtask

    task automatic wait_gnt(input int r, output int l);
        int start = cyc;
        l = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk50);
            if (gnt[r]) begin
                l = cyc - start;
                return;
            end
        end
        chk("gnt_timeout", 64'(gnt), 64'(2'b01 << r));
    endtask

    task automatic do_write(input int r, input logic [2:0] d, input logic [3:0] n, input logic dp, output int l);
        @(posedge clk50); #1;
        set_req(r, d, n, dp);
        exp_gnt.push_back(2'b01 << r);
        wait_gnt(r, l);
        @(posedge clk50); #1 req[r] = 1'b0;
        m_nib[d] = n;
        m_dp[d]  = dp;
    endtask

    task automatic do_reset();
        chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
        chk("commit_queue_drained", 64'(exp_commit.size()), 64'd0);
        @(posedge clk50); #1;
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk50);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_hex", hex_all, 64'd0);
        chk("rst_cnt", 64'(commit_cnt), 64'd0);
        @(posedge clk50); #1 reset = 1'b0;
        model_reset();
    endtask

    // Monitor: every grant and every commit must match the head of its queue
    initial begin
        commit_t c;
        logic [1:0] g;
        forever begin
            @(negedge clk50);
            if (!reset) begin
                if (gnt != 2'b00) begin
                    if (exp_gnt.size() == 0) begin
                        chk("unexpected_gnt", 64'(gnt), 64'd0);
                    end else begin
                        g = exp_gnt.pop_front();
                        chk("gnt_winner", 64'(gnt), 64'(g));
                    end
                end
                if (commit_cnt == prev_cnt + 16'd1) begin
                    if (exp_commit.size() == 0) begin
                        chk("unexpected_commit", 64'(commit_cnt), 64'(prev_cnt));
                    end else begin
                        c = exp_commit.pop_front();
                        chk("commit_cnt", 64'(commit_cnt), 64'(c.cnt));
                        chk("commit_hex", hex_all, c.hexes);
                    end
                end
            end
            prev_cnt = commit_cnt;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        int last_cyc;
        int n_gnt;
        reset      = 1'b1;
        req        = 2'b00;
        req_digit  = '0;
        req_nibble = '0;
        req_dp     = '0;
        vga_vs     = 1'b1;
        model_reset();
        repeat (2) @(posedge clk50);
        @(negedge clk50);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_hex", hex_all, 64'd0);
        chk("rst_cnt", 64'(commit_cnt), 64'd0);
        @(posedge clk50); #1 reset = 1'b0;
        repeat (3) @(negedge clk50);
        chk("idle_hex_blank", hex_all, 64'd0);

        // Three frames with no writes
        repeat (3) vs_commit();
        chk("cnt_after_3", 64'(commit_cnt), 64'd3);

        // Single write is staged, shown only at the next frame
        do_write(0, 3'd2, 4'hA, 1'b1, lat);
        chk("gnt_latency", 64'(lat), 64'd1);
        repeat (3) @(negedge clk50);
        chk("hex2_hold", 64'(hex2), 64'(m_hex[2]));
        vs_commit();
        chk("hex2_A_dp", 64'(hex2), 64'hF7);

        // Both requesters held: round-robin, one write every 2 cycles
        do_reset();
        @(posedge clk50); #1;
        set_req(0, 3'd5, 4'h1, 1'b0);
        set_req(1, 3'd5, 4'h2, 1'b0);
        exp_gnt.push_back(2'b01);
        exp_gnt.push_back(2'b10);
        exp_gnt.push_back(2'b01);
        exp_gnt.push_back(2'b10);
        n_gnt    = 0;
        last_cyc = 0;
        for (int k = 0; k < 40 && n_gnt < 4; k++) begin
            @(negedge clk50);
            if (gnt != 2'b00) begin
                if (n_gnt > 0) chk("rr_spacing", 64'(cyc - last_cyc), 64'd2);
                last_cyc = cyc;
                n_gnt++;
            end
        end
        chk("rr_grant_count", 64'(n_gnt), 64'd4);
        @(posedge clk50); #1 req = 2'b00;
        m_nib[5] = 4'h2;
        vs_commit();
        chk("rr_last_wins", 64'(hex5), 64'h5B);

        // Frame edge coinciding with a write; the waiting request yields to the commit
        @(posedge clk50); #1;
        set_req(0, 3'd7, 4'h8, 1'b0);
        set_req(1, 3'd6, 4'h3, 1'b0);
        exp_gnt.push_back(2'b01);
        exp_gnt.push_back(2'b10);
        wait_gnt(0, lat);
        m_nib[7] = 4'h8;
        push_commit();
        vga_vs = 1'b0;
        @(posedge clk50); #1;
        vga_vs = 1'b1;
        req[0] = 1'b0;
        wait_gnt(1, lat);
        chk("edge_write_delay", 64'(lat), 64'd3);
        chk("edge_commit_first", 64'(commit_cnt), 64'(exp_cnt));
        chk("edge_hex7", 64'(hex7), 64'h7F);
        @(posedge clk50); #1 req[1] = 1'b0;
        m_nib[6] = 4'h3;
        vs_commit();
        chk("edge_hex6", 64'(hex6), 64'h4F);

        // Leading-zero pattern: digit0=5, digit2=3
        do_reset();
        do_write(0, 3'd0, 4'h5, 1'b0, lat);
        do_write(1, 3'd2, 4'h3, 1'b0, lat);
        vs_commit();
`ifdef SEG_BLANK_LEADING_ZEROS_EN
        chk("lz_pattern", hex_all, 64'h00000000_004F3F6D);
`else
        chk("lz_pattern", hex_all, 64'h3F3F3F3F_3F4F3F6D);
`endif

        // Reset in the middle of a write discards it
        do_reset();
        @(posedge clk50); #1;
        set_req(0, 3'd1, 4'hF, 1'b0);
        exp_gnt.push_back(2'b01);
        wait_gnt(0, lat);
        #2;
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk50);
        chk("rst_mid_write_gnt", 64'(gnt), 64'd0);
        @(posedge clk50); #1 reset = 1'b0;
        model_reset();
        @(negedge clk50);
        chk("rst_mid_write_cnt", 64'(commit_cnt), 64'd0);
        vs_commit();
        chk("rst_mid_write_hex1", 64'(hex1), 64'(m_hex[1]));
        chk("rst_mid_write_cnt1", 64'(commit_cnt), 64'd1);

        repeat (3) @(negedge clk50);
        chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
        chk("commit_queue_drained", 64'(exp_commit.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
